// File: rtl/tb_uart_xcvr.sv
// tb_uart_xcvr: 8N1 UART transceiver. The transmitter uses a start/busy/clear handshake.
// The receiver is double-synchronized and emits one-cycle valid and error strobes.
module tb_uart_xcvr #(
    parameter int CLKS_PER_BIT = 4167
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ser_rx,
    output logic       ser_tx,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_clear_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_STOP, T_DONE} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_IDLE} rx_state_t;

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state     <= T_IDLE;
            tx_cnt       <= '0;
            tx_bit       <= '0;
            tx_shift     <= '0;
            ser_tx       <= 1'b1;
            tx_busy      <= 1'b0;
            tx_clear_req <= 1'b0;
        end else begin
            case (tx_state)
                T_IDLE: if (tx_start) begin
                    tx_shift <= tx_data;
                    ser_tx   <= 1'b0;
                    tx_busy  <= 1'b1;
                    tx_cnt   <= '0;
                    tx_state <= T_START;
                end
                T_START: if (tx_cnt == LAST) begin
                    tx_cnt   <= '0;
                    tx_bit   <= '0;
                    ser_tx   <= tx_shift[0];
                    tx_state <= T_DATA;
                end else tx_cnt <= tx_cnt + 1'b1;
                // the next data bit is always tx_shift[1] because the register shifts as it goes
                T_DATA: if (tx_cnt == LAST) begin
                    tx_cnt   <= '0;
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_bit   <= tx_bit + 3'd1;
                    ser_tx   <= (&tx_bit) ? 1'b1 : tx_shift[1];
                    tx_state <= (&tx_bit) ? T_STOP : T_DATA;
                end else tx_cnt <= tx_cnt + 1'b1;
                T_STOP: if (tx_cnt == LAST) begin
                    tx_cnt       <= '0;
                    tx_busy      <= 1'b0;
                    tx_clear_req <= 1'b1;
                    tx_state     <= T_DONE;
                end else tx_cnt <= tx_cnt + 1'b1;
                T_DONE: if (!tx_start) begin
                    tx_clear_req <= 1'b0;
                    tx_state     <= T_IDLE;
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_s1, rx_s2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            rx_s1    <= ser_rx;
            rx_s2    <= rx_s1;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            case (rx_state)
                R_IDLE: if (!rx_s2) begin
                    rx_cnt   <= '0;
                    rx_state <= R_START;
                end
                // re-check the start bit at its centre to reject short glitches
                R_START: if (rx_cnt == HALF) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? R_IDLE : R_DATA;
                end else rx_cnt <= rx_cnt + 1'b1;
                R_DATA: if (rx_cnt == LAST) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                    rx_state <= (&rx_bit) ? R_STOP : R_DATA;
                end else rx_cnt <= rx_cnt + 1'b1;
                R_STOP: if (rx_cnt == LAST) begin
                    rx_cnt   <= '0;
                    rx_data  <= rx_s2 ? rx_shift : rx_data;
                    rx_valid <= rx_s2;
                    rx_error <= !rx_s2;
                    rx_state <= rx_s2 ? R_IDLE : R_WAIT_IDLE;
                end else rx_cnt <= rx_cnt + 1'b1;
                R_WAIT_IDLE: if (rx_s2) rx_state <= R_IDLE;
                default: rx_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tb_uart_xcvr.sv
// tb_tb_uart_xcvr: randomized scoreboard bench for tb_uart_xcvr with CLKS_PER_BIT=16.
// TX waveforms are checked against a slot model; RX events are popped from an expected queue.
`timescale 1ns/100ps
module tb_tb_uart_xcvr;
    localparam int CPB = 16;

    logic       clock = 0, reset = 1, ser_rx, ser_tx, tx_start = 0;
    logic [7:0] tx_data = 0, rx_data;
    logic       tx_busy, tx_clear_req, rx_valid, rx_error;
    logic       loop = 0, drv = 1;
    int         checks = 0, errors = 0, rx_events = 0;
    logic [7:0] model_rx = 0;

    typedef struct packed {logic err; logic [7:0] data;} ev_t;
    ev_t q[$];
    ev_t e;

    assign ser_rx = loop ? ser_tx : drv;

    tb_uart_xcvr #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .reset(reset), .ser_rx(ser_rx), .ser_tx(ser_tx),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .tx_clear_req(tx_clear_req), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_error(rx_error)
    );

    always #12.5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // slot 0 is the start bit, 1..8 the data bits LSB first, 9 the stop bit
    function automatic logic wave_bit(input logic [7:0] b, input int slot);
        return slot == 0 ? 1'b0 : slot == 9 ? 1'b1 : b[slot-1];
    endfunction

    always @(negedge clock) begin
        if (!reset && (rx_valid || rx_error)) begin
            rx_events++;
            if (q.size() == 0) check("rx_unexpected", {31'b0, rx_valid | rx_error}, 0);
            else begin
                e = q.pop_front();
                check("rx_valid", {31'b0, rx_valid}, {31'b0, !e.err});
                check("rx_error", {31'b0, rx_error}, {31'b0, e.err});
                check("rx_data", {24'b0, rx_data}, {24'b0, e.data});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold, input int chg_at, input logic [7:0] chg);
        int mism = 0, busy_bad = 0, hold_bad = 0;
        if (loop) begin
            q.push_back('{err: 1'b0, data: b});
            model_rx = b;
        end
        tx_data  = b;
        tx_start = 1;
        @(posedge clock);
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge clock);
            if (k == chg_at) tx_data = chg;
            if (ser_tx !== wave_bit(b, k / CPB)) mism++;
            if (tx_busy !== 1'b1) busy_bad++;
        end
        check("tx_wave", mism, 0);
        check("tx_busy_high", busy_bad, 0);
        @(negedge clock);
        check("tx_busy_end", {31'b0, tx_busy}, 0);
        check("tx_clear_req_set", {31'b0, tx_clear_req}, 1);
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            if (tx_clear_req !== 1'b1 || tx_busy !== 1'b0 || ser_tx !== 1'b1) hold_bad++;
        end
        check("tx_hold_no_refire", hold_bad, 0);
        tx_start = 0;
        @(negedge clock);
        check("tx_clear_req_drop", {31'b0, tx_clear_req}, 0);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            q.push_back('{err: 1'b0, data: b});
            model_rx = b;
        end else q.push_back('{err: 1'b1, data: model_rx});
        for (int s = 0; s < 10; s++) begin
            drv = (s == 9) ? stop : wave_bit(b, s);
            repeat (CPB) @(negedge clock);
        end
        drv = 1;
        if (!stop) repeat (CPB) @(negedge clock);
    endtask

    initial begin
        int n, mism;
        logic [7:0] b;
        repeat (3) @(negedge clock);
        check("rst_ser_tx", {31'b0, ser_tx}, 1);
        check("rst_busy", {31'b0, tx_busy}, 0);
        check("rst_clear", {31'b0, tx_clear_req}, 0);
        check("rst_rx_data", {24'b0, rx_data}, 0);
        check("rst_rx_strobes", {30'b0, rx_valid, rx_error}, 0);
        reset = 0;
        loop  = 1;
        repeat (2) @(negedge clock);
        send_byte(8'hA5, 40, -1, 0);
        send_byte(8'h00, 1, -1, 0);
        send_byte(8'h01, 0, -1, 0);
        send_byte(8'h02, 2, -1, 0);
        send_byte(8'h3C, 1, 70, 8'hFF);
        for (int i = 0; i < 6; i++)
            send_byte(8'($urandom), $urandom_range(0, 5), $urandom_range(0, 159), 8'($urandom));
        repeat (4) @(negedge clock);
        loop = 0;
        drv  = 0;
        repeat (4) @(negedge clock);
        drv = 1;
        n   = rx_events;
        repeat (40) @(negedge clock);
        check("glitch_no_event", rx_events, n);
        drive_frame(8'h5A, 1);
        drive_frame(8'h55, 0);
        drive_frame(8'h12, 1);
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            if (i % 2 == 0)
                fork
                    drive_frame(b, $urandom_range(0, 3) != 0);
                    send_byte(8'($urandom), $urandom_range(0, 3), -1, 0);
                join
            else drive_frame(b, $urandom_range(0, 3) != 0);
        end
        repeat (CPB) @(negedge clock);
        tx_data  = 8'hF7;
        tx_start = 1;
        @(posedge clock);
        repeat (71) @(negedge clock);
        check("abort_pre_bit3", {31'b0, ser_tx}, 0);
        reset = 1;
        #1;
        check("abort_ser_tx", {31'b0, ser_tx}, 1);
        check("abort_busy", {31'b0, tx_busy}, 0);
        tx_start = 0;
        model_rx = 0;
        @(negedge clock);
        reset = 0;
        @(negedge clock);
        loop = 1;
        send_byte(8'hC3, 1, -1, 0);
        mism = 0;
        for (int k = 0; k < 300 && q.size() != 0; k++) @(negedge clock);
        check("sb_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
